// File: rtl/shifter_input_conditioner.sv
// shifter_input_conditioner
// Synchronizes and debounces four active-low push buttons and seven control
// switches in front of the 4-bit shifter core. Each accepted button press
// toggles one bit of the held operand register `a`. All outputs are
// registered.
// Optional feature macro: SHIFTER_SW_DEBOUNCE_EN. When it is defined, every
// switch bit gets the same debounce logic as the buttons. When it is not
// defined, the switches are only passed through a 2-flop synchronizer.
module shifter_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_n,
    input  logic [2:0] sw_f,
    input  logic [1:0] sw_b,
    input  logic [1:0] sw_c,
    output logic [3:0] a,
    output logic [2:0] f,
    output logic [1:0] b,
    output logic [1:0] c,
    output logic [3:0] press,
    output logic       changed
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // A new level is accepted on the cycle its counter would reach DEBOUNCE_CYCLES.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Button synchronizer and debounce state
    logic [3:0]    btn_s1, btn_s2;
    logic [3:0]    s, s_next, btn_accept;
    logic [CW-1:0] cnt      [4];
    logic [CW-1:0] cnt_next [4];

    // Switch path: sw_q is the register that drives f/b/c
    logic [6:0] sw_raw, sw_s1, sw_q, sw_q_next;
    logic [3:0] press_next, a_next;
    logic       changed_next;

    assign sw_raw = {sw_f, sw_b, sw_c};

    // Button synchronizers (reset released) and per-button debounce state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1 <= 4'hF;
            btn_s2 <= 4'hF;
            s      <= 4'hF;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            btn_s1 <= btn_n;
            btn_s2 <= btn_s1;
            s      <= s_next;
            for (int i = 0; i < 4; i++) cnt[i] <= cnt_next[i];
        end
    end

    // Button debounce: count while the synced level differs, accept on the last count
    always_comb begin
        s_next     = s;
        btn_accept = 4'b0;
        for (int i = 0; i < 4; i++) begin
            cnt_next[i] = '0;
            if (btn_s2[i] != s[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    s_next[i]     = btn_s2[i];
                    btn_accept[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

`ifdef SHIFTER_SW_DEBOUNCE_EN
    logic [6:0]    sw_s2;
    logic [CW-1:0] sw_cnt      [7];
    logic [CW-1:0] sw_cnt_next [7];

    // Switch synchronizers and per-bit debounce counters; sw_q is the stable level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
            for (int i = 0; i < 7; i++) sw_cnt[i] <= '0;
        end else begin
            sw_s1 <= sw_raw;
            sw_s2 <= sw_s1;
            for (int i = 0; i < 7; i++) sw_cnt[i] <= sw_cnt_next[i];
        end
    end

    // Switch debounce, identical in behaviour to the button debounce
    always_comb begin
        sw_q_next = sw_q;
        for (int i = 0; i < 7; i++) begin
            sw_cnt_next[i] = '0;
            if (sw_s2[i] != sw_q[i]) begin
                if (sw_cnt[i] == CNT_LAST) begin
                    sw_q_next[i] = sw_s2[i];
                end else begin
                    sw_cnt_next[i] = sw_cnt[i] + CW'(1);
                end
            end
        end
    end
`else
    // First switch synchronizer stage; sw_q acts as the second stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sw_s1 <= '0;
        else     sw_s1 <= sw_raw;
    end

    // Second synchronizer stage feeds f/b/c directly
    always_comb begin
        sw_q_next = sw_s1;
    end
`endif

    // Press is a 1->0 transition of the stable state; it toggles the matching a bit
    always_comb begin
        press_next   = btn_accept & s;
        a_next       = a ^ press_next;
        changed_next = (a_next != a) || (sw_q_next != sw_q);
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a       <= 4'b0;
            press   <= 4'b0;
            changed <= 1'b0;
            sw_q    <= '0;
        end else begin
            a       <= a_next;
            press   <= press_next;
            changed <= changed_next;
            sw_q    <= sw_q_next;
        end
    end

    assign f = sw_q[6:4];
    assign b = sw_q[3:2];
    assign c = sw_q[1:0];

endmodule

// File: tb/tb_shifter_input_conditioner.sv
// Directed bench for shifter_input_conditioner with DEBOUNCE_CYCLES = 4.
// Also handles builds with SHIFTER_SW_DEBOUNCE_EN defined.
module tb_shifter_input_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_n = 4'hF;
    logic [2:0] sw_f = '0;
    logic [1:0] sw_b = '0;
    logic [1:0] sw_c = '0;
    logic [3:0] a;
    logic [2:0] f;
    logic [1:0] b;
    logic [1:0] c;
    logic [3:0] press;
    logic       changed;

    int total = 0;
    int fails = 0;

    shifter_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .sw_f(sw_f), .sw_b(sw_b), .sw_c(sw_c),
        .a(a), .f(f), .b(b), .c(c), .press(press), .changed(changed)
    );

    // Clock
    always #5 clk = ~clk;

    // Advance past one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // ---------------- Reset ----------------
        step();
        step();
        #3 rst = 1'b1;
        #1;
        check("rst_a", {4'b0, a}, 8'h00);
        check("rst_fbc", {1'b0, f, b, c}, 8'h00);
        check("rst_press", {4'b0, press}, 8'h00);
        check("rst_changed", {7'b0, changed}, 8'h00);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_idle", {a, press}, 8'h00);
            check("post_rst_changed", {7'b0, changed}, 8'h00);
        end

        // ---------------- Clean press on btn_n[2] ----------------
        btn_n = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            step();
            check("clean_wait_press", {4'b0, press}, 8'h00);
            check("clean_wait_a", {4'b0, a}, 8'h00);
        end
        step();  // edge 5
        check("clean_press", {4'b0, press}, 8'h04);
        check("clean_a", {4'b0, a}, 8'h04);
        check("clean_changed", {7'b0, changed}, 8'h01);
        step();
        check("clean_press_once", {4'b0, press}, 8'h00);
        check("clean_changed_once", {7'b0, changed}, 8'h00);
        for (int k = 0; k < 14; k++) begin
            step();
            check("clean_hold", {a, press}, 8'h40);
        end
        btn_n = 4'hF;
        for (int k = 0; k < 10; k++) begin
            step();
            check("clean_release", {a, press}, 8'h40);
            check("clean_release_changed", {7'b0, changed}, 8'h00);
        end

        // ---------------- Bounce on btn_n[0] ----------------
        for (int k = 0; k < 20; k++) begin
            btn_n[0] = ((k % 4) == 3);
            step();
            check("bounce", {a, press}, 8'h40);
        end
        btn_n = 4'hF;
        for (int k = 0; k < 8; k++) begin
            step();
            check("bounce_settle", {a, press}, 8'h40);
        end

        // ---------------- Simultaneous press btn 0 and 2 ----------------
        btn_n = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            step();
            check("simul_wait", {a, press}, 8'h40);
        end
        step();
        check("simul_press", {4'b0, press}, 8'h05);
        check("simul_a", {4'b0, a}, 8'h01);
        check("simul_changed", {7'b0, changed}, 8'h01);
        step();
        check("simul_press_once", {4'b0, press}, 8'h00);
        btn_n = 4'hF;
        for (int k = 0; k < 10; k++) begin
            step();
            check("simul_release", {a, press}, 8'h10);
        end

        // ---------------- Switch path ----------------
        sw_f = 3'b101;
        sw_b = 2'b11;
        sw_c = 2'b10;
        step();  // edge 0
        check("sw_edge0", {1'b0, f, b, c}, 8'h00);
        check("sw_edge0_changed", {7'b0, changed}, 8'h00);
`ifdef SHIFTER_SW_DEBOUNCE_EN
        for (int k = 1; k < 5; k++) begin
            step();
            check("sw_db_wait", {1'b0, f, b, c}, 8'h00);
            check("sw_db_wait_changed", {7'b0, changed}, 8'h00);
        end
        step();  // edge 5
        check("sw_db_update", {1'b0, f, b, c}, {1'b0, 7'b1011110});
        check("sw_db_changed", {7'b0, changed}, 8'h01);
        step();
        check("sw_db_changed_once", {7'b0, changed}, 8'h00);
        sw_b = 2'b01;
        step();
        step();
        sw_b = 2'b11;
        for (int k = 0; k < 8; k++) begin
            step();
            check("sw_glitch", {1'b0, f, b, c}, {1'b0, 7'b1011110});
            check("sw_glitch_changed", {7'b0, changed}, 8'h00);
        end
`else
        step();  // edge 1
        check("sw_update", {1'b0, f, b, c}, {1'b0, 7'b1011110});
        check("sw_changed", {7'b0, changed}, 8'h01);
        step();
        check("sw_changed_once", {7'b0, changed}, 8'h00);
        check("sw_hold", {1'b0, f, b, c}, {1'b0, 7'b1011110});
`endif
        check("sw_a_untouched", {4'b0, a}, 8'h01);

        // ---------------- Reset mid-debounce on btn_n[1] ----------------
        btn_n = 4'b1101;
        step();  // edge 0
        check("mid_edge0", {4'b0, press}, 8'h00);
        step();  // edge 1
        step();  // edge 2
        check("mid_before_rst", {4'b0, press}, 8'h00);
        #3 rst = 1'b1;
        #1;
        check("mid_rst_a", {4'b0, a}, 8'h00);
        check("mid_rst_press", {4'b0, press}, 8'h00);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("mid_wait", {a, press}, 8'h00);
        end
        step();  // sixth edge after reset release
        check("mid_press", {4'b0, press}, 8'h02);
        check("mid_a", {4'b0, a}, 8'h02);
        check("mid_changed", {7'b0, changed}, 8'h01);
        step();
        check("mid_press_once", {4'b0, press}, 8'h00);
        btn_n = 4'hF;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
